kv_line_fetch_responder: RTL and testbench
==========================================

// Module: kv_line_fetch_responder
// PURPOSE
//  Memory-side responder for the cache line-fetch interface. Accepts one line-fetch
//  request (word address), reads LINE_SIZE words from a word-wide backing-memory port
//  one at a time, assembles the line and returns it as a LINE_SIZE-entry word array.
//  Sits between the cache fetch port and the memory/bus adapter.
// PARAMETERS
//  DATA_WIDTH  32  width of one word
//  ADDR_WIDTH  32  word address width (low LOW_W bits = word offset in line)
//  LINE_SIZE   4   words per line; power of two, >= 2; LOW_W = $clog2(LINE_SIZE)
// PORTS
//  i_clk           in   1                  clock, all state on rising edge
//  i_rst           in   1                  async active-high reset
//  i_fetch_addr    in   ADDR_WIDTH         requested word address
//  i_fetch_valid   in   1                  request valid
//  o_fetch_ready   out  1                  request accepted when valid&ready
//  o_fetch_data    out  DATA_WIDTH x LINE_SIZE  returned line, [k] = word at offset k
//  o_fetch_valid   out  1                  line response valid
//  i_fetch_ready   in   1                  line response consumed when valid&ready
//  o_mem_addr      out  ADDR_WIDTH         word address to memory
//  o_mem_req       out  1                  memory read request
//  i_mem_gnt       in   1                  request taken when req&gnt
//  i_mem_rdata     in   DATA_WIDTH         read data
//  i_mem_rvalid    in   1                  read data valid (>=1 cycle after gnt)
// BEHAVIOUR
//  - Reset (async, i_rst=1): state IDLE; o_fetch_ready=0 while in reset, 1 after;
//    o_fetch_valid=0, o_mem_req=0, o_mem_addr=0, o_fetch_data all 0, counter 0.
//  - FSM IDLE -> REQ -> WAIT -> (REQ | RESP) -> IDLE. One memory read outstanding.
//  - IDLE: o_fetch_ready=1. On valid&ready latch base={addr[ADDR_WIDTH-1:LOW_W],0},
//    start offset, word count=0; -> REQ. o_fetch_ready=0 in all other states.
//  - REQ: o_mem_req=1, o_mem_addr=base|cur_offset; held stable until gnt. On gnt -> WAIT.
//  - WAIT: o_mem_req=0. On rvalid store rdata into line[cur_offset]; count++,
//    cur_offset = cur_offset+1 mod LINE_SIZE (wraps). If count was LINE_SIZE-1 -> RESP
//    else -> REQ. rvalid in any other state is ignored.
//  - RESP: o_fetch_valid=1, o_fetch_data stable; on i_fetch_ready -> IDLE next cycle.
//    Backpressure holds RESP indefinitely. No new request accepted before IDLE.
//  - Latency (gnt same cycle as req, rvalid 1 cycle after gnt): request accepted at edge
//    T, o_fetch_valid rises at T+2*LINE_SIZE.
//  - o_fetch_data registers only written in WAIT on rvalid; words untouched by
//    the current line hold the previous value (all are written before RESP).
//  - Reset mid-operation aborts the line; a late i_mem_rvalid after reset is ignored.
// CONFIGURATION
//  KV_FETCH_CRITICAL_WORD_FIRST_EN
//   defined:   start offset = i_fetch_addr[LOW_W-1:0]; memory read in wrap order
//              from the requested word.
//   undefined: start offset = 0; reads always offset 0..LINE_SIZE-1.
//   Either way o_fetch_data is in offset order and returned only when complete.
// STRUCTURE
//  - kv_pkg: typedef enum logic [1:0] {KV_FR_IDLE, KV_FR_REQ, KV_FR_WAIT, KV_FR_RESP}
//    kv_fetch_resp_state_e; shared line-word typedef for DATA_WIDTH words.
//  - Single module, no sub-modules; counter and offset are LOW_W(+1)-bit registers.
// TESTING
//  1 Reset: i_rst=1 mid-REQ -> o_mem_req=0, o_fetch_valid=0, o_fetch_ready=1 after release.
//  2 Basic: addr 0x100, gnt immediate, rdata=addr*3 -> mem addrs 0x100..0x103, line
//    {0x300,0x303,0x306,0x309}, o_fetch_valid at T+8.
//  3 Gnt stall: gnt low 3 cycles on word 1 -> o_mem_addr 0x101 held, line correct, T+11.
//  4 Response backpressure: i_fetch_ready low 5 cycles -> valid/data stable, no new
//    request accepted (o_fetch_ready=0) until handshake.
//  5 CWF (macro on): addr 0x206 LINE_SIZE 4 -> mem order 0x206,0x207,0x204,0x205;
//    macro off -> 0x204..0x207; o_fetch_data identical in both builds.
//  6 Spurious rvalid in IDLE/REQ -> ignored; back-to-back requests 0x10,0x20 -> two
//    correct lines in order.

Source files
------------

// File: rtl/kv_pkg.sv
// Shared types for the key-value line-fetch responder.
// The default widths and line size live here so the top and its users agree on them.
package kv_pkg;

    localparam int KV_DATA_WIDTH = 32;
    localparam int KV_ADDR_WIDTH = 32;
    localparam int KV_LINE_SIZE  = 4;

    typedef enum logic [1:0] {
        KV_FR_IDLE = 2'd0,
        KV_FR_REQ  = 2'd1,
        KV_FR_WAIT = 2'd2,
        KV_FR_RESP = 2'd3
    } kv_fetch_resp_state_e;

    typedef logic [KV_DATA_WIDTH-1:0] kv_line_word_t;

endpackage

// File: rtl/kv_line_fetch_responder.sv
// Line-fetch responder: turns one line request into LINE_SIZE single-word memory reads.
// Optional feature macro: KV_FETCH_CRITICAL_WORD_FIRST_EN (read in wrap order from the requested word).
module kv_line_fetch_responder
    import kv_pkg::*;
#(
    parameter int DATA_WIDTH = KV_DATA_WIDTH,
    parameter int ADDR_WIDTH = KV_ADDR_WIDTH,
    parameter int LINE_SIZE  = KV_LINE_SIZE
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [ADDR_WIDTH-1:0] i_fetch_addr,
    input  logic                  i_fetch_valid,
    output logic                  o_fetch_ready,
    output logic [DATA_WIDTH-1:0] o_fetch_data [LINE_SIZE],
    output logic                  o_fetch_valid,
    input  logic                  i_fetch_ready,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic                  o_mem_req,
    input  logic                  i_mem_gnt,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata,
    input  logic                  i_mem_rvalid
);

    localparam int LOW_W = $clog2(LINE_SIZE);
    localparam int CNT_W = LOW_W + 1;
    localparam int HI_W  = ADDR_WIDTH - LOW_W;

    kv_fetch_resp_state_e  state_r, state_s;
    logic [HI_W-1:0]       base_hi_r, base_hi_s;
    logic [LOW_W-1:0]      off_r, off_s;
    logic [CNT_W-1:0]      cnt_r, cnt_s;
    logic [LOW_W-1:0]      start_off_s;
    logic                  wr_en_s;
    logic                  fetch_ready_r;
    logic                  fetch_valid_r;
    logic                  mem_req_r;
    logic [ADDR_WIDTH-1:0] mem_addr_r;
    logic [DATA_WIDTH-1:0] line_r [LINE_SIZE];

`ifdef KV_FETCH_CRITICAL_WORD_FIRST_EN
    assign start_off_s = i_fetch_addr[LOW_W-1:0];
`else
    assign start_off_s = {LOW_W{1'b0}};
    logic unused_addr_lo_s;
    assign unused_addr_lo_s = ^i_fetch_addr[LOW_W-1:0];
`endif

    // Next-state and datapath update; one memory read is outstanding at a time.
    always_comb begin
        state_s   = state_r;
        base_hi_s = base_hi_r;
        off_s     = off_r;
        cnt_s     = cnt_r;
        wr_en_s   = 1'b0;
        case (state_r)
            KV_FR_IDLE: begin
                if (i_fetch_valid && fetch_ready_r) begin
                    base_hi_s = i_fetch_addr[ADDR_WIDTH-1:LOW_W];
                    off_s     = start_off_s;
                    cnt_s     = {CNT_W{1'b0}};
                    state_s   = KV_FR_REQ;
                end else begin
                    state_s = KV_FR_IDLE;
                end
            end
            KV_FR_REQ: begin
                if (i_mem_gnt) begin
                    state_s = KV_FR_WAIT;
                end else begin
                    state_s = KV_FR_REQ;
                end
            end
            KV_FR_WAIT: begin
                if (i_mem_rvalid) begin
                    wr_en_s = 1'b1;
                    cnt_s   = cnt_r + CNT_W'(1);
                    off_s   = off_r + LOW_W'(1);
                    if (cnt_r == CNT_W'(LINE_SIZE - 1)) begin
                        state_s = KV_FR_RESP;
                    end else begin
                        state_s = KV_FR_REQ;
                    end
                end else begin
                    state_s = KV_FR_WAIT;
                end
            end
            KV_FR_RESP: begin
                if (i_fetch_ready) begin
                    state_s = KV_FR_IDLE;
                end else begin
                    state_s = KV_FR_RESP;
                end
            end
            default: begin
                state_s = KV_FR_IDLE;
            end
        endcase
    end

    // State, line buffer and registered outputs (decoded from the next state so they align with it).
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r       <= KV_FR_IDLE;
            base_hi_r     <= {HI_W{1'b0}};
            off_r         <= {LOW_W{1'b0}};
            cnt_r         <= {CNT_W{1'b0}};
            fetch_ready_r <= 1'b0;
            fetch_valid_r <= 1'b0;
            mem_req_r     <= 1'b0;
            mem_addr_r    <= {ADDR_WIDTH{1'b0}};
            for (int k = 0; k < LINE_SIZE; k++) begin
                line_r[k] <= {DATA_WIDTH{1'b0}};
            end
        end else begin
            state_r       <= state_s;
            base_hi_r     <= base_hi_s;
            off_r         <= off_s;
            cnt_r         <= cnt_s;
            fetch_ready_r <= (state_s == KV_FR_IDLE);
            fetch_valid_r <= (state_s == KV_FR_RESP);
            mem_req_r     <= (state_s == KV_FR_REQ);
            if (state_s == KV_FR_REQ) begin
                mem_addr_r <= {base_hi_s, off_s};
            end
            if (wr_en_s) begin
                line_r[off_r] <= i_mem_rdata;
            end
        end
    end

    assign o_fetch_ready = fetch_ready_r;
    assign o_fetch_valid = fetch_valid_r;
    assign o_mem_req     = mem_req_r;
    assign o_mem_addr    = mem_addr_r;
    assign o_fetch_data  = line_r;

endmodule

// File: tb/tb_kv_line_fetch_responder.sv
// Directed bench for kv_line_fetch_responder with a line-level reference model and a
// memory responder whose read data is address*3.
module tb_kv_line_fetch_responder;

    localparam int LS = 4;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic [31:0] i_fetch_addr;
    logic        i_fetch_valid;
    logic        o_fetch_ready;
    logic [31:0] o_fetch_data [LS];
    logic        o_fetch_valid;
    logic        i_fetch_ready;
    logic [31:0] o_mem_addr;
    logic        o_mem_req;
    logic        i_mem_gnt = 1'b0;
    logic [31:0] i_mem_rdata = 32'h0;
    logic        i_mem_rvalid = 1'b0;

    kv_line_fetch_responder dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_fetch_addr (i_fetch_addr),
        .i_fetch_valid(i_fetch_valid),
        .o_fetch_ready(o_fetch_ready),
        .o_fetch_data (o_fetch_data),
        .o_fetch_valid(o_fetch_valid),
        .i_fetch_ready(i_fetch_ready),
        .o_mem_addr   (o_mem_addr),
        .o_mem_req    (o_mem_req),
        .i_mem_gnt    (i_mem_gnt),
        .i_mem_rdata  (i_mem_rdata),
        .i_mem_rvalid (i_mem_rvalid)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cnt = 0;
    int done_cnt = 0;
    int acc_cyc = 0;
    int exp_rise = 0;
    int last_lat = 0;
    int granted = 0;
    int stall_word = 0;
    int stall_left = 0;
    int spur_mode = 0;
    bit busy = 1'b0;
    bit rise_seen = 1'b0;
    bit pending = 1'b0;
    logic [31:0] pend_addr = 32'h0;
    logic [31:0] exp_line [LS];
    logic [31:0] last_line [LS];
    logic [31:0] exp_addr_q [$];
    logic [31:0] grant_log [$];

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=event expected=none", name);
    endtask

    // Reference model, memory responder and per-cycle comparison, all on the falling edge.
    initial begin
        logic [31:0] base;
        int start;
        forever begin
            @(negedge i_clk);
            if (pending) begin
                i_mem_rvalid = 1'b1;
                i_mem_rdata  = pend_addr * 32'd3;
                pending      = 1'b0;
            end else if (spur_mode == 1 || (spur_mode == 2 && o_mem_req)) begin
                i_mem_rvalid = 1'b1;
                i_mem_rdata  = 32'hDEAD_BEEF;
                spur_mode    = 0;
            end else begin
                i_mem_rvalid = 1'b0;
                i_mem_rdata  = 32'h0;
            end

            if (i_rst) begin
                i_mem_gnt = 1'b0;
                chk("rst_mem_req", o_mem_req, 0);
                chk("rst_fetch_valid", o_fetch_valid, 0);
                chk("rst_fetch_ready", o_fetch_ready, 0);
                chk("rst_mem_addr", o_mem_addr, 0);
                for (int k = 0; k < LS; k++) chk($sformatf("rst_data%0d", k), o_fetch_data[k], 0);
                busy = 1'b0;
                rise_seen = 1'b0;
                exp_addr_q.delete();
            end else begin
                if (o_fetch_valid) begin
                    if (!busy) begin
                        fail("valid_unexpected");
                    end else begin
                        if (!rise_seen) begin
                            chk("valid_cycle", cyc, exp_rise);
                            chk("reads_left", exp_addr_q.size(), 0);
                            rise_seen = 1'b1;
                            last_lat  = cyc - acc_cyc;
                        end
                        for (int k = 0; k < LS; k++)
                            chk($sformatf("line_word%0d", k), o_fetch_data[k], exp_line[k]);
                        chk("ready_in_resp", o_fetch_ready, 0);
                        if (i_fetch_ready) begin
                            busy = 1'b0;
                            rise_seen = 1'b0;
                            last_line = exp_line;
                            done_cnt++;
                        end
                    end
                end

                if (i_fetch_valid && o_fetch_ready) begin
                    if (busy) fail("accept_while_busy");
                    acc_cnt++;
                    busy = 1'b1;
                    rise_seen = 1'b0;
                    acc_cyc = cyc + 1;
                    exp_rise = acc_cyc + 2 * LS;
                    granted = 0;
                    grant_log.delete();
                    exp_addr_q.delete();
                    base = i_fetch_addr & ~32'(LS - 1);
`ifdef KV_FETCH_CRITICAL_WORD_FIRST_EN
                    start = int'(i_fetch_addr % LS);
`else
                    start = 0;
`endif
                    for (int k = 0; k < LS; k++) begin
                        exp_line[k] = (base + 32'(k)) * 32'd3;
                        exp_addr_q.push_back(base + 32'((start + k) % LS));
                    end
                end

                if (o_mem_req) begin
                    if (!busy || exp_addr_q.size() == 0) begin
                        fail("req_unexpected");
                        i_mem_gnt = 1'b0;
                    end else begin
                        chk("mem_addr", o_mem_addr, exp_addr_q[0]);
                        if (granted == stall_word && stall_left > 0) begin
                            i_mem_gnt = 1'b0;
                            stall_left--;
                            exp_rise++;
                        end else begin
                            i_mem_gnt = 1'b1;
                            pend_addr = o_mem_addr;
                            pending   = 1'b1;
                            grant_log.push_back(o_mem_addr);
                            void'(exp_addr_q.pop_front());
                            granted++;
                        end
                    end
                end else begin
                    i_mem_gnt = 1'b0;
                end
            end
        end
    end

    task automatic tick;
        @(posedge i_clk);
        #1;
    endtask

    task automatic send_req(input logic [31:0] a);
        int n0;
        n0 = acc_cnt;
        i_fetch_addr  = a;
        i_fetch_valid = 1'b1;
        for (int i = 0; i < 60 && acc_cnt == n0; i++) tick();
        if (acc_cnt == n0) fail("accept_timeout");
        i_fetch_valid = 1'b0;
    endtask

    task automatic wait_done(input int target);
        for (int i = 0; i < 300 && done_cnt < target; i++) tick();
        if (done_cnt < target) fail("response_timeout");
    endtask

    task automatic chk_line(input string name, input logic [31:0] w0, input logic [31:0] step);
        for (int k = 0; k < LS; k++)
            chk($sformatf("%s_w%0d", name, k), last_line[k], w0 + step * 32'(k));
    endtask

    initial begin
        int n;
        i_rst = 1'b1;
        i_fetch_addr = 32'h0;
        i_fetch_valid = 1'b0;
        i_fetch_ready = 1'b1;
        repeat (3) tick();
        i_rst = 1'b0;
        tick();
        chk("ready_after_reset", o_fetch_ready, 1);

        // Reset while a read request is stalled in REQ.
        stall_word = 0;
        stall_left = 6;
        send_req(32'h40);
        tick();
        tick();
        chk("req_before_reset", o_mem_req, 1);
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        stall_left = 0;
        spur_mode = 1;
        tick();
        chk("ready_after_abort", o_fetch_ready, 1);
        chk("req_after_abort", o_mem_req, 0);
        chk("valid_after_abort", o_fetch_valid, 0);
        tick();

        // Basic line, immediate grant.
        send_req(32'h100);
        wait_done(1);
        chk("basic_latency", last_lat, 8);
        chk_line("basic", 32'h300, 32'd3);
        for (int k = 0; k < LS; k++) chk($sformatf("basic_order%0d", k), grant_log[k], 32'h100 + 32'(k));

        // Grant withheld for three cycles on the second word.
        stall_word = 1;
        stall_left = 3;
        send_req(32'h101);
        wait_done(2);
        chk("stall_latency", last_lat, 11);
        chk("stall_addr1", grant_log[1], 32'h101);
        chk_line("stall", 32'h300, 32'd3);

        // Response backpressure with a competing request held on the fetch port.
        i_fetch_ready = 1'b0;
        send_req(32'h300);
        for (int i = 0; i < 60 && !o_fetch_valid; i++) tick();
        chk("bp_valid_up", o_fetch_valid, 1);
        i_fetch_addr = 32'h400;
        i_fetch_valid = 1'b1;
        n = acc_cnt;
        repeat (5) tick();
        chk("bp_no_accept", acc_cnt, n);
        chk("bp_valid_held", o_fetch_valid, 1);
        chk("bp_ready_low", o_fetch_ready, 0);
        i_fetch_ready = 1'b1;
        wait_done(3);
        chk_line("bp", 32'h900, 32'd3);
        for (int i = 0; i < 60 && acc_cnt == n; i++) tick();
        chk("bp_next_accept", acc_cnt, n + 1);
        i_fetch_valid = 1'b0;
        wait_done(4);
        chk_line("bp_next", 32'hC00, 32'd3);

        // Unaligned request: wrap order only with critical-word-first.
        send_req(32'h206);
        wait_done(5);
        chk_line("cwf", 32'h60C, 32'd3);
`ifdef KV_FETCH_CRITICAL_WORD_FIRST_EN
        chk("cwf_order0", grant_log[0], 32'h206);
        chk("cwf_order1", grant_log[1], 32'h207);
        chk("cwf_order2", grant_log[2], 32'h204);
        chk("cwf_order3", grant_log[3], 32'h205);
`else
        chk("cwf_order0", grant_log[0], 32'h204);
        chk("cwf_order1", grant_log[1], 32'h205);
        chk("cwf_order2", grant_log[2], 32'h206);
        chk("cwf_order3", grant_log[3], 32'h207);
`endif

        // Spurious rvalid in IDLE and in REQ, then back-to-back requests.
        spur_mode = 1;
        tick();
        tick();
        stall_word = 0;
        stall_left = 2;
        spur_mode = 2;
        send_req(32'h10);
        send_req(32'h20);
        n = done_cnt;
        chk("b2b_first_done", n, 6);
        chk_line("b2b_first", 32'h30, 32'd3);
        wait_done(7);
        chk_line("b2b_second", 32'h60, 32'd3);
        chk("spurious_consumed", spur_mode, 0);

        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
